csa_accumulator: RTL and testbench

Sequential accumulator that sits directly downstream of the carry-save adder stage in the float MAC datapath. It takes a stream of unsigned significand products and keeps a running sum in redundant (sum/carry) form, so there is no carry propagation per accepted addend. On the last addend it resolves the redundant pair into a binary result with a multi-cycle 4-bit-slice ripple, then presents the result with an exact overflow flag. Valid/ready handshakes on both sides.

---
 rtl/csa_accumulator.sv | 139 +++++++++++++
 tb/tb_csa_accumulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Carry-save accumulator: keeps a running sum of unsigned addends in redundant
// sum/carry form, then resolves it with a 4-bit-slice ripple and exact overflow.
module csa_accumulator #(
  parameter int W  = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic          clear,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          out_ovf,
  output logic [15:0]   out_count
);

  localparam int NS = AW / 4;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   s_q, c_q, r_q;
  logic            ovf_q, rc_q;
  logic [KW-1:0]   k_q;
  logic [15:0]     count_q;

  logic            accept, last_slice;
  logic [AW-1:0]   x, base_s, base_c, maj, s_sh, c_sh, r_next;
  logic            base_ovf;
  logic [15:0]     base_count, count_inc;
  logic [KW+1:0]   shift;
  logic [4:0]      slice_sum;

  assign accept     = in_valid & in_ready;
  assign last_slice = (k_q == KW'(NS - 1));
  assign x          = AW'(in_data);

  // clear takes effect before a same-cycle addend, so the update starts from zero
  assign base_s     = clear ? '0 : s_q;
  assign base_c     = clear ? '0 : c_q;
  assign base_ovf   = clear ? 1'b0 : ovf_q;
  assign base_count = clear ? 16'd0 : count_q;
  assign count_inc  = (base_count == 16'hFFFF) ? base_count : base_count + 16'd1;
  assign maj        = (base_s & base_c) | (base_s & x) | (base_c & x);

  // Current resolve slice, selected by shifting rather than a variable part-select
  assign shift     = {k_q, 2'b00};
  assign s_sh      = s_q >> shift;
  assign c_sh      = c_q >> shift;
  assign slice_sum = {1'b0, s_sh[3:0]} + {1'b0, c_sh[3:0]} + {4'b0000, rc_q};
  assign r_next    = (r_q & ~(AW'(4'hF) << shift)) | (AW'(slice_sum[3:0]) << shift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = RESOLVE;
      end
      RESOLVE: if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= '0;
      c_q       <= '0;
      r_q       <= '0;
      ovf_q     <= 1'b0;
      rc_q      <= 1'b0;
      k_q       <= '0;
      count_q   <= 16'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_count <= 16'd0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            s_q     <= base_s ^ base_c ^ x;
            c_q     <= maj << 1;
            ovf_q   <= base_ovf | maj[AW-1];
            count_q <= count_inc;
            if (in_last) begin
              k_q  <= '0;
              rc_q <= 1'b0;
            end
          end else if (clear) begin
            s_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            count_q <= 16'd0;
          end
        end
        RESOLVE: begin
          r_q  <= r_next;
          rc_q <= slice_sum[4];
          k_q  <= k_q + KW'(1);
          if (last_slice) begin
            ovf_q     <= ovf_q | slice_sum[4];
            out_data  <= r_next;
            out_ovf   <= ovf_q | slice_sum[4];
            out_count <= count_q;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            s_q       <= '0;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            count_q   <= 16'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator: directed groups push hand-computed results,
// an independent monitor pops and compares on every output handshake.
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, clear;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_ovf;
  logic [15:0] out_data, out_count;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic [15:0] count;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  csa_accumulator #(.W(8), .AW(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .clear(clear), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every result the consumer actually takes
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0d with no result expected", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
        check("out_count", 32'(out_count), 32'(e.count));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic last, input logic clr);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    clear    = clr;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic o, input logic [15:0] c);
    exp_t e;
    e.data  = d;
    e.ovf   = o;
    e.count = c;
    sb.push_back(e);
  endtask

  // n copies of value v, last one flagged
  task automatic send_repeat(input logic [7:0] v, input int n);
    for (int i = 1; i <= n; i++) send(v, (i == n), 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    in_data = 8'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic group with latency and single-cycle out_valid
    push(16'd15, 1'b0, 16'd3);
    send(8'd3, 1'b0, 1'b0);
    send(8'd5, 1'b0, 1'b0);
    send(8'd7, 1'b1, 1'b0);
    @(negedge clk);
    check("basic_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("basic_valid_edge%0d", i), 32'(out_valid), 32'(i == 4));
    end
    check("basic_in_ready_back", 32'(in_ready), 32'd1);
    wait_drain("basic_drain");

    // Overflow: 258 * 255 = 65790 -> 254
    push(16'd254, 1'b1, 16'd258);
    send_repeat(8'd255, 258);
    wait_drain("ovf_drain");

    // Exact fill: 257 * 255 = 65535, no overflow
    push(16'd65535, 1'b0, 16'd257);
    send_repeat(8'd255, 257);
    wait_drain("fill_drain");

    // Clear together with the last accept
    push(16'd4, 1'b0, 16'd1);
    send(8'd10, 1'b0, 1'b0);
    send(8'd20, 1'b0, 1'b0);
    send(8'd4, 1'b1, 1'b1);
    wait_drain("clear_accept_drain");

    // Clear alone, then a single-addend group
    push(16'd9, 1'b0, 16'd1);
    send(8'd30, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    send(8'd9, 1'b1, 1'b0);
    wait_drain("clear_alone_drain");

    // Backpressure: 100 + 200 = 300 held for 10 cycles
    out_ready = 1'b0;
    push(16'd300, 1'b0, 16'd2);
    send(8'd100, 1'b0, 1'b0);
    send(8'd200, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_data_held", 32'(out_data), 32'd300);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_valid_after", 32'(out_valid), 32'd0);
    check("bp_data_kept", 32'(out_data), 32'd300);
    check("bp_queue_empty", 32'(sb.size()), 32'd0);

    // Reset two cycles into RESOLVE; that group's result is discarded
    send(8'd50, 1'b0, 1'b0);
    send(8'd60, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_ovf", 32'(out_ovf), 32'd0);
    check("mid_rst_count", 32'(out_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    push(16'd2, 1'b0, 16'd2);
    send(8'd1, 1'b0, 1'b0);
    send(8'd1, 1'b1, 1'b0);
    wait_drain("post_rst_drain");

    repeat (8) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
